alu_mul_sequencer: RTL and testbench



---
 rtl/alu_mul_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that reuses the team ALU (fixed to add) to form the
// low W bits of a*b, terminating early once the remaining multiplier bits are zero.

module alu #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [1:0]   i_op,
    output logic [W-1:0] o_out,
    output logic         o_co,
    output logic         o_v,
    output logic         o_n,
    output logic         o_z
);
    logic [W-1:0] w_b_eff;
    logic [W:0]   w_sum;
    logic         w_is_sub;
    logic         w_is_arith;

    assign w_is_sub   = (i_op == 2'b01);
    assign w_is_arith = ~i_op[1];
    assign w_b_eff    = w_is_sub ? ~i_b : i_b;
    assign w_sum      = {1'b0, i_a} + {1'b0, w_b_eff} + {{W{1'b0}}, w_is_sub};

    always_comb begin
        o_out = w_sum[W-1:0];
        unique case (i_op)
            2'b00, 2'b01: o_out = w_sum[W-1:0];
            2'b10:        o_out = i_a & i_b;
            2'b11:        o_out = i_a | i_b;
            default:      o_out = w_sum[W-1:0];
        endcase
    end

    assign o_co = w_is_arith & w_sum[W];
    assign o_v  = w_is_arith & (i_a[W-1] == w_b_eff[W-1]) & (w_sum[W-1] != i_a[W-1]);
    assign o_n  = o_out[W-1];
    assign o_z  = (o_out == '0);
endmodule

module alu_mul_sequencer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product,
    output logic         N,
    output logic         Z
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        r_state;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_mcand;
    logic [W-1:0]  r_mplier;
    logic [CW-1:0] r_count;

    logic [W-1:0]  w_alu_out;
    logic [W-1:0]  w_acc_next;
    logic [W-1:0]  w_mplier_shr;
    logic          w_last;
    logic          w_alu_co;
    logic          w_alu_v;
    logic          w_alu_n;
    logic          w_alu_z;
    logic          w_unused_flags;

    alu #(
        .W (W)
    ) u_alu (
        .i_a   (r_acc),
        .i_b   (r_mcand),
        .i_op  (2'b00),
        .o_out (w_alu_out),
        .o_co  (w_alu_co),
        .o_v   (w_alu_v),
        .o_n   (w_alu_n),
        .o_z   (w_alu_z)
    );

    // Truncated product needs no carry/overflow/flag information from the ALU.
    assign w_unused_flags = w_alu_co ^ w_alu_v ^ w_alu_n ^ w_alu_z;

    assign w_acc_next   = r_mplier[0] ? w_alu_out : r_acc;
    assign w_mplier_shr = r_mplier >> 1;
    assign w_last       = (w_mplier_shr == '0) || (r_count == CW'(W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            N        <= 1'b0;
            Z        <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_count  <= '0;
                        busy     <= 1'b1;
                        r_state  <= StRun;
                    end
                end
                StRun: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shr;
                    r_count  <= r_count + 1'b1;
                    if (w_last) begin
                        r_state <= StDone;
                        done    <= 1'b1;
                        product <= w_acc_next;
                        N       <= w_acc_next[W-1];
                        Z       <= (w_acc_next == '0);
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: a vector table plus hand-written
// sequences for start-while-busy and reset-abort behaviour.

module tb_alu_mul_sequencer;
    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] product;
    logic         N;
    logic         Z;

    int n_pass;
    int n_total;

    alu_mul_sequencer #(
        .W (W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .N       (N),
        .Z       (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_p;
        logic         exp_n;
        logic         exp_z;
        int           exp_edges;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called just after a falling edge. Returns edges from the accepting edge
    // until done is seen, busy-high cycles, and whether product held steady.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int inj,
                          output int edges, output int busy_cnt, output bit stable);
        logic [W-1:0] p0;
        p0       = product;
        a        = ta;
        b        = tb_v;
        start    = 1'b1;
        busy_cnt = 0;
        stable   = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        a     = ~ta;
        b     = ~tb_v;
        while (!done && edges < 100) begin
            if (busy) busy_cnt++;
            if (product !== p0) stable = 1'b0;
            if (edges == inj) begin
                start = 1'b1;
                a     = 32'd9;
                b     = 32'd9;
            end else if (edges == inj + 1) begin
                start = 1'b0;
                a     = 32'hDEAD_BEEF;
                b     = 32'h0000_0003;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (busy) busy_cnt++;
    endtask

    vec_t vecs[7];
    int   edges;
    int   busy_cnt;
    bit   stable;
    int   extra_done;

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;

        vecs[0] = '{32'd3,          32'd5,          32'd15,         1'b0, 1'b0, 4};
        vecs[1] = '{32'h1234_5678,  32'd0,          32'd0,          1'b0, 1'b1, 2};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 1'b0, 33};
        vecs[3] = '{32'h0001_0000,  32'h0001_0000,  32'd0,          1'b0, 1'b1, 18};
        vecs[4] = '{32'h8000_0000,  32'd1,          32'h8000_0000,  1'b1, 1'b0, 2};
        vecs[5] = '{32'd6,          32'd7,          32'd42,         1'b0, 1'b0, 4};
        vecs[6] = '{32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB,  1'b1, 1'b0, 4};

        #3 reset = 1'b1;
        #2;
        chk("reset busy",    {31'd0, busy}, 32'd0);
        chk("reset done",    {31'd0, done}, 32'd0);
        chk("reset product", product,       32'd0);
        chk("reset N",       {31'd0, N},    32'd0);
        chk("reset Z",       {31'd0, Z},    32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].va, vecs[i].vb, -1, edges, busy_cnt, stable);
            chk($sformatf("vec%0d edges", i),    edges,               vecs[i].exp_edges);
            chk($sformatf("vec%0d product", i),  product,             vecs[i].exp_p);
            chk($sformatf("vec%0d N", i),        {31'd0, N},          {31'd0, vecs[i].exp_n});
            chk($sformatf("vec%0d Z", i),        {31'd0, Z},          {31'd0, vecs[i].exp_z});
            chk($sformatf("vec%0d busy cyc", i), busy_cnt,            vecs[i].exp_edges);
            chk($sformatf("vec%0d stable", i),   {31'd0, stable},     32'd1);
            @(negedge clk);
            chk($sformatf("vec%0d done pulse", i), {30'd0, done, busy}, 32'd0);
            chk($sformatf("vec%0d held", i),       product,             vecs[i].exp_p);
        end

        // Abort mid-RUN: a=6, b=0xF0, reset just after the third edge.
        a     = 32'd6;
        b     = 32'h0000_00F0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort busy",    {31'd0, busy}, 32'd0);
        chk("abort done",    {31'd0, done}, 32'd0);
        chk("abort product", product,       32'd0);
        chk("abort N",       {31'd0, N},    32'd0);
        chk("abort Z",       {31'd0, Z},    32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("abort no done", {31'd0, done}, 32'd0);
        #1 reset = 1'b0;
        run_op(32'd6, 32'd7, -1, edges, busy_cnt, stable);
        chk("post-reset edges",   edges,   4);
        chk("post-reset product", product, 32'd42);
        @(negedge clk);

        // start while busy must be ignored; first result delivered unchanged.
        run_op(32'd2, 32'h8000_0000, 5, edges, busy_cnt, stable);
        chk("ignore edges",   edges,          33);
        chk("ignore product", product,        32'd0);
        chk("ignore Z",       {31'd0, Z},     32'd1);
        chk("ignore N",       {31'd0, N},     32'd0);
        chk("ignore stable",  {31'd0, stable}, 32'd1);
        extra_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        chk("ignore single done", extra_done, 0);
        chk("ignore held",        product,    32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
